mem_addr_seq: RTL and testbench

- Registered, parametrised successor to the combinational memory-address select in the multicycle datapath.
- Selects a base address from PC, ALUOut, RD or one of three exception-vector constants.
- Issues a single access or a multi-beat burst to memory with a req/ack handshake, generating base + beat*STRIDE per beat.
- Sits between the control unit (start, sel) and the memory address/request pins.

---
 rtl/mem_addr_pkg.sv | 30 +++
 rtl/mem_addr_src_mux.sv | 37 +++
 rtl/mem_addr_seq.sv | 178 +++++++++++++++++
 tb/tb_mem_addr_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_addr_pkg.sv
// mem_addr_pkg: select codes, sequencer state encoding and default
// exception-vector addresses shared by the address sequencer and its source mux.
package mem_addr_pkg;

    // Base-address select codes driven by the control unit
    localparam logic [2:0] SEL_PC   = 3'b000;
    localparam logic [2:0] SEL_ALU  = 3'b001;
    localparam logic [2:0] SEL_VEC0 = 3'b010;
    localparam logic [2:0] SEL_VEC1 = 3'b011;
    localparam logic [2:0] SEL_VEC2 = 3'b100;
    localparam logic [2:0] SEL_RD   = 3'b101;

    // Default exception vectors: opcode-invalid, overflow, div-by-zero
    localparam int unsigned DEF_VEC0 = 255;
    localparam int unsigned DEF_VEC1 = 254;
    localparam int unsigned DEF_VEC2 = 253;

    // Sequencer states
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StDone  = 2'b10
    } state_e;

    // True when the select picks one of the fixed exception vectors
    function automatic logic sel_is_vec(input logic [2:0] sel);
        return (sel == SEL_VEC0) || (sel == SEL_VEC1) || (sel == SEL_VEC2);
    endfunction

endpackage

// File: rtl/mem_addr_src_mux.sv
// mem_addr_src_mux: combinational six-way base-address select. Flags the
// unused select codes as illegal and reports whether a vector was chosen.
module mem_addr_src_mux
    import mem_addr_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned VEC0   = DEF_VEC0,
    parameter int unsigned VEC1   = DEF_VEC1,
    parameter int unsigned VEC2   = DEF_VEC2
) (
    input  logic [2:0]        sel,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] base,
    output logic              sel_illegal,
    output logic              sel_vec
);

    // Decode the select code into a base address; codes 110/111 are illegal
    always_comb begin
        base        = '0;
        sel_illegal = 1'b0;
        case (sel)
            SEL_PC:   base = pc_addr;
            SEL_ALU:  base = alu_addr;
            SEL_VEC0: base = ADDR_W'(VEC0);
            SEL_VEC1: base = ADDR_W'(VEC1);
            SEL_VEC2: base = ADDR_W'(VEC2);
            SEL_RD:   base = rd_addr;
            default:  sel_illegal = 1'b1;
        endcase
    end

    assign sel_vec = sel_is_vec(sel);

endmodule

// File: rtl/mem_addr_seq.sv
// mem_addr_seq: registered memory-address sequencer. Latches a base address
// and burst length on start, then issues base + beat*STRIDE per beat over a
// req/ack handshake, pulsing done after the last beat.
// Optional build macro MEM_ADDR_ALIGN_CHECK_EN adds a misalign output that
// rejects non-vector bases that are not a multiple of STRIDE.
module mem_addr_seq
    import mem_addr_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BL_W   = 3,
    parameter int unsigned STRIDE = 4,
    parameter int unsigned VEC0   = DEF_VEC0,
    parameter int unsigned VEC1   = DEF_VEC1,
    parameter int unsigned VEC2   = DEF_VEC2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        sel,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BL_W-1:0]   burst_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [BL_W-1:0]   beat_idx,
    output logic              busy,
    output logic              done,
    output logic              sel_err
`ifdef MEM_ADDR_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [BL_W-1:0]   blen_q, blen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [BL_W-1:0]   beat_q, beat_d;
    logic              done_q, done_d;
    logic              sel_err_q, sel_err_d;

    logic [ADDR_W-1:0] mux_base;
    logic              sel_illegal;
    logic              sel_vec;
    logic [BL_W-1:0]   beat_nxt;

    mem_addr_src_mux #(
        .ADDR_W (ADDR_W),
        .VEC0   (VEC0),
        .VEC1   (VEC1),
        .VEC2   (VEC2)
    ) u_src_mux (
        .sel         (sel),
        .pc_addr     (pc_addr),
        .alu_addr    (alu_addr),
        .rd_addr     (rd_addr),
        .base        (mux_base),
        .sel_illegal (sel_illegal),
        .sel_vec     (sel_vec)
    );

`ifdef MEM_ADDR_ALIGN_CHECK_EN
    // STRIDE is a power of two, so its low bits form the alignment mask
    localparam logic [ADDR_W-1:0] STRIDE_MASK = ADDR_W'(STRIDE - 1);

    logic misalign_q, misalign_d;
    logic align_bad;

    // Vector selects are fixed addresses and never count as misaligned
    assign align_bad = !sel_vec && (|(mux_base & STRIDE_MASK));
    assign misalign  = misalign_q;
`else
    logic unused_sel_vec;
    assign unused_sel_vec = sel_vec;
`endif

    assign beat_nxt = beat_q + BL_W'(1);

    // Next-state and next-output decode; pulse outputs default low every cycle
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        blen_d     = blen_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        beat_d     = beat_q;
        done_d     = 1'b0;
        sel_err_d  = 1'b0;
`ifdef MEM_ADDR_ALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (sel_illegal) begin
                        sel_err_d = 1'b1;
                    end
`ifdef MEM_ADDR_ALIGN_CHECK_EN
                    else if (align_bad) begin
                        misalign_d = 1'b1;
                    end
`endif
                    else begin
                        base_d     = mux_base;
                        blen_d     = burst_len;
                        mem_addr_d = mux_base;
                        mem_req_d  = 1'b1;
                        beat_d     = '0;
                        state_d    = StIssue;
                    end
                end
            end
            StIssue: begin
                if (mem_ack) begin
                    if (beat_q == blen_q) begin
                        mem_req_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = StDone;
                    end else begin
                        // Back-to-back beat: req stays high, address advances
                        beat_d     = beat_nxt;
                        mem_addr_d = base_q + ADDR_W'(beat_nxt) * STRIDE_A;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight request at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            base_q     <= '0;
            blen_q     <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            beat_q     <= '0;
            done_q     <= 1'b0;
            sel_err_q  <= 1'b0;
`ifdef MEM_ADDR_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            blen_q     <= blen_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
            sel_err_q  <= sel_err_d;
`ifdef MEM_ADDR_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_req  = mem_req_q;
    assign beat_idx = beat_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// tb_mem_addr_seq: scoreboard bench for mem_addr_seq. Stimulus pushes the
// expected beats/done/sel_err (and misalign when MEM_ADDR_ALIGN_CHECK_EN is
// defined) into a queue; a monitor pops and compares as the DUT presents them.
module tb_mem_addr_seq;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BL_W   = 3;
    localparam int unsigned STRIDE = 4;

    localparam int EV_BEAT = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_MIS  = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [2:0]        sel;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] alu_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [BL_W-1:0]   burst_len;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [BL_W-1:0]   beat_idx;
    logic              busy;
    logic              done;
    logic              sel_err;
`ifdef MEM_ADDR_ALIGN_CHECK_EN
    logic              misalign;
`endif

    always #5 clk = ~clk;

    mem_addr_seq #(
        .ADDR_W (ADDR_W),
        .BL_W   (BL_W),
        .STRIDE (STRIDE),
        .VEC0   (255),
        .VEC1   (254),
        .VEC2   (253)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sel       (sel),
        .pc_addr   (pc_addr),
        .alu_addr  (alu_addr),
        .rd_addr   (rd_addr),
        .burst_len (burst_len),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .beat_idx  (beat_idx),
        .busy      (busy),
        .done      (done),
        .sel_err   (sel_err)
`ifdef MEM_ADDR_ALIGN_CHECK_EN
        ,
        .misalign  (misalign)
`endif
    );

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [2:0]  beat;
    } evt_t;

    evt_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_evt(input int kind, input logic [31:0] addr, input logic [2:0] beat);
        evt_t e;
        e.kind = kind;
        e.addr = addr;
        e.beat = beat;
        sb_q.push_back(e);
    endtask

    // Reference model: what the whole access should look like from its inputs
    task automatic model_start(input logic [2:0] s, input logic [31:0] pc, input logic [31:0] alu,
                               input logic [31:0] rd, input logic [2:0] bl,
                               output bit issue, output logic [31:0] base);
        issue = 1'b0;
        base  = 32'h0;
        case (s)
            3'd0: base = pc;
            3'd1: base = alu;
            3'd2: base = 32'd255;
            3'd3: base = 32'd254;
            3'd4: base = 32'd253;
            3'd5: base = rd;
            default: begin
                push_evt(EV_ERR, 32'h0, 3'd0);
                return;
            end
        endcase
`ifdef MEM_ADDR_ALIGN_CHECK_EN
        if (!(s inside {3'd2, 3'd3, 3'd4}) && (base % STRIDE) != 0) begin
            push_evt(EV_MIS, 32'h0, 3'd0);
            return;
        end
`endif
        for (int i = 0; i <= int'(bl); i++) begin
            push_evt(EV_BEAT, base + 32'(i * int'(STRIDE)), 3'(i));
        end
        push_evt(EV_DONE, 32'h0, 3'd0);
        issue = 1'b1;
    endtask

    task automatic check_evt(input int kind, input logic [31:0] addr, input logic [2:0] beat);
        evt_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_evt: got kind %0d addr 0x%0h, expected no event (t=%0t)",
                     kind, addr, $time);
            return;
        end
        e = sb_q.pop_front();
        chk("evt_kind", 32'(kind), 32'(e.kind));
        if (kind == EV_BEAT && e.kind == EV_BEAT) begin
            chk("beat_addr", addr, e.addr);
            chk("beat_idx", 32'(beat), 32'(e.beat));
        end
    endtask

    // Monitor: sample on the falling edge, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (mem_req && mem_ack) check_evt(EV_BEAT, mem_addr, beat_idx);
                if (done)               check_evt(EV_DONE, 32'h0, 3'd0);
                if (sel_err)            check_evt(EV_ERR, 32'h0, 3'd0);
`ifdef MEM_ADDR_ALIGN_CHECK_EN
                if (misalign)           check_evt(EV_MIS, 32'h0, 3'd0);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(1) == 1) a[1:0] = 2'b00;
        if ($urandom_range(7) == 0) a[31:8] = 24'hFFFFFF;
        return a;
    endfunction

    // One access from IDLE until the DUT is idle again
    task automatic do_txn(input logic [2:0] s, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] rd, input logic [2:0] bl, input int ack_pct,
                          input bit stray);
        bit          issue;
        logic [31:0] base;
        int          cycles;
        start     = 1'b1;
        sel       = s;
        pc_addr   = pc;
        alu_addr  = alu;
        rd_addr   = rd;
        burst_len = bl;
        mem_ack   = 1'($urandom_range(1));
        model_start(s, pc, alu, rd, bl, issue, base);
        tick();
        start = 1'b0;
        chk("txn_busy", 32'(busy), 32'(issue));
        chk("txn_req", 32'(mem_req), 32'(issue));
        if (issue) begin
            chk("txn_first_addr", mem_addr, base);
            chk("txn_first_beat", 32'(beat_idx), 32'h0);
        end
        cycles = 0;
        while (busy && cycles < 400) begin
            mem_ack = ($urandom_range(99) < ack_pct);
            if (stray) begin
                start    = 1'($urandom_range(1));
                sel      = 3'($urandom_range(7));
                pc_addr  = $urandom;
                alu_addr = $urandom;
                rd_addr  = $urandom;
                burst_len = 3'($urandom_range(7));
            end
            tick();
            cycles++;
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        if (busy) chk("txn_timeout", 32'(busy), 32'h0);
        else if (issue && ack_pct >= 100) chk("txn_busy_cycles", 32'(cycles), 32'(int'(bl) + 2));
    endtask

    initial begin
        bit          issue;
        logic [31:0] base;

        reset_n   = 1'b0;
        start     = 1'b0;
        sel       = 3'd0;
        pc_addr   = '0;
        alu_addr  = '0;
        rd_addr   = '0;
        burst_len = '0;
        mem_ack   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_beat", 32'(beat_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sel_err", 32'(sel_err), 32'h0);
`ifdef MEM_ADDR_ALIGN_CHECK_EN
        chk("rst_misalign", 32'(misalign), 32'h0);
`endif
        reset_n = 1'b1;
        tick();

        // Single beat from PC, ack after two wait cycles
        start     = 1'b1;
        sel       = 3'd0;
        pc_addr   = 32'h0000_0040;
        burst_len = 3'd0;
        model_start(3'd0, 32'h40, 32'h0, 32'h0, 3'd0, issue, base);
        tick();
        start = 1'b0;
        chk("t1_req_c1", 32'(mem_req), 32'h1);
        chk("t1_addr", mem_addr, 32'h40);
        chk("t1_busy", 32'(busy), 32'h1);
        tick();
        chk("t1_req_c2", 32'(mem_req), 32'h1);
        tick();
        chk("t1_req_c3", 32'(mem_req), 32'h1);
        chk("t1_addr_held", mem_addr, 32'h40);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t1_req_drop", 32'(mem_req), 32'h0);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_busy_done", 32'(busy), 32'h1);
        tick();
        chk("t1_done_once", 32'(done), 32'h0);
        chk("t1_busy_fall", 32'(busy), 32'h0);

        // Four-beat ALUOut burst, ack always high
        do_txn(3'd1, 32'h0, 32'h100, 32'h0, 3'd3, 100, 1'b0);
        // Exception vectors and illegal selects
        do_txn(3'd2, 32'h0, 32'h0, 32'h0, 3'd0, 70, 1'b0);
        do_txn(3'd3, 32'h0, 32'h0, 32'h0, 3'd0, 70, 1'b0);
        do_txn(3'd4, 32'h0, 32'h0, 32'h0, 3'd0, 70, 1'b0);
        do_txn(3'd7, 32'h0, 32'h0, 32'h0, 3'd2, 100, 1'b0);
        tick();
        chk("t3_no_req", 32'(mem_req), 32'h0);
        do_txn(3'd6, 32'h0, 32'h0, 32'h0, 3'd0, 100, 1'b0);
        // RD base wrapping past all-ones, start re-pulsed mid-burst
        do_txn(3'd5, 32'h0, 32'h0, 32'hFFFF_FFFC, 3'd1, 100, 1'b1);

        // Asynchronous reset during beat 2 of a four-beat burst
        tick();
        start     = 1'b1;
        sel       = 3'd1;
        alu_addr  = 32'h300;
        burst_len = 3'd3;
        model_start(3'd1, 32'h0, 32'h300, 32'h0, 3'd3, issue, base);
        tick();
        start   = 1'b0;
        mem_ack = 1'b1;
        tick();
        tick();
        chk("t5_beat2", 32'(beat_idx), 32'h2);
        chk("t5_addr2", mem_addr, 32'h308);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_addr", mem_addr, 32'h0);
        chk("t5_async_req", 32'(mem_req), 32'h0);
        chk("t5_async_beat", 32'(beat_idx), 32'h0);
        chk("t5_async_busy", 32'(busy), 32'h0);
        chk("t5_async_done", 32'(done), 32'h0);
        chk("t5_dropped", 32'(sb_q.size()), 32'h3);
        sb_q.delete();
        mem_ack = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        do_txn(3'd1, 32'h0, 32'h200, 32'h0, 3'd3, 100, 1'b0);

        // Misaligned then aligned ALUOut base
        do_txn(3'd1, 32'h0, 32'h102, 32'h0, 3'd0, 100, 1'b0);
        do_txn(3'd1, 32'h0, 32'h104, 32'h0, 3'd0, 100, 1'b0);

        // Randomised accesses
        for (int n = 0; n < 40; n++) begin
            int pct;
            case ($urandom_range(2))
                0:       pct = 100;
                1:       pct = 60;
                default: pct = 25;
            endcase
            do_txn(3'($urandom_range(7)), rnd_addr(), rnd_addr(), rnd_addr(),
                   3'($urandom_range(7)), pct, 1'($urandom_range(1)));
            repeat ($urandom_range(2)) tick();
        end

        tick();
        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
